pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 122 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with an optional 2-entry skid buffer, flush with a
// saturating drop counter, and zeroed control bits in every bubble.
module pipe_skid_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              alive;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              accept;
  logic              retire;
  logic [1:0]        n_drop;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  drop_next;

  // alive is low during reset, so in_ready stays registered-state driven.
  assign in_ready = alive & ~flush &
                    ((SKID != 0) ? (state != FULL) : (~out_valid | out_ready));
  assign accept   = in_valid & in_ready;
  assign retire   = out_valid & out_ready;

  // Entries lost to a flush: the head unless it retires this cycle, plus the skid.
  always_comb begin
    n_drop    = {1'b0, out_valid & ~out_ready} + {1'b0, state == FULL};
    cnt_sum   = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);
    if (cnt_sum[CNT_W]) begin
      drop_next = {CNT_W{1'b1}};
    end else begin
      drop_next = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= EMPTY;
      alive     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_ctrl  <= {CTRL_W{1'b0}};
      skid_data <= {DATA_W{1'b0}};
      skid_ctrl <= {CTRL_W{1'b0}};
      drop_cnt  <= {CNT_W{1'b0}};
    end else begin
      alive <= 1'b1;
      if (flush) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
        out_data  <= {DATA_W{1'b0}};
        out_ctrl  <= {CTRL_W{1'b0}};
        skid_data <= {DATA_W{1'b0}};
        skid_ctrl <= {CTRL_W{1'b0}};
        drop_cnt  <= drop_next;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              state     <= ONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_ctrl  <= in_ctrl;
            end
          end
          ONE: begin
            if (accept && retire) begin
              out_data <= in_data;
              out_ctrl <= in_ctrl;
            end else if (accept) begin
              // Only reachable with a skid entry: the head is stalled.
              state     <= FULL;
              skid_data <= in_data;
              skid_ctrl <= in_ctrl;
            end else if (retire) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
              out_data  <= {DATA_W{1'b0}};
              out_ctrl  <= {CTRL_W{1'b0}};
            end
          end
          FULL: begin
            if (retire) begin
              state     <= ONE;
              out_data  <= skid_data;
              out_ctrl  <= skid_ctrl;
              skid_data <= {DATA_W{1'b0}};
              skid_ctrl <= {CTRL_W{1'b0}};
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_ctrl  <= {CTRL_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: three instances (skid, no skid, 2-bit counter) share
// one directed stimulus stream and are checked against a FIFO-level model.
module tb_pipe_skid_reg;
  localparam int DW = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic [2:0]    ir, ov;
  logic [2:0][DW-1:0] od;
  logic [2:0][CW-1:0] oc;
  logic [7:0]    dc0, dc1;
  logic [1:0]    dc2;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(8)) u_skid (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ctrl(oc[0]), .drop_cnt(dc0));
  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(8)) u_single (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ctrl(oc[1]), .drop_cnt(dc1));
  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(2)) u_sat (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_ctrl(oc[2]), .drop_cnt(dc2));

  int n_chk = 0;
  int n_fail = 0;

  // Model: per instance a FIFO of {ctrl,data} with capacity 2 (skid) or 1.
  logic [CW+DW-1:0] mq [3][2];
  int  mc [3] = '{0, 0, 0};
  int  md [3] = '{0, 0, 0};
  bit  ma [3] = '{1'b0, 1'b0, 1'b0};
  int  skd [3] = '{1, 0, 1};
  int  mx [3] = '{255, 255, 3};
  bit  chk_en = 1'b0;

  function automatic bit m_rdy(int i);
    if (!ma[i] || flush) return 1'b0;
    if (skd[i] != 0) return mc[i] < 2;
    return (mc[i] == 0) || out_ready;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        bit acc, rel;
        int dropped;
        acc = in_valid && m_rdy(i);
        rel = (mc[i] > 0) && out_ready;
        if (!rstn) begin
          mc[i] = 0; md[i] = 0; ma[i] = 1'b0;
        end else begin
          ma[i] = 1'b1;
          if (flush) begin
            dropped = mc[i] - (rel ? 1 : 0);
            md[i] = (md[i] + dropped > mx[i]) ? mx[i] : md[i] + dropped;
            mc[i] = 0;
          end else begin
            if (rel) begin
              mq[i][0] = mq[i][1];
              mc[i]--;
            end
            if (acc) begin
              mq[i][mc[i]] = {in_ctrl, in_data};
              mc[i]++;
            end
          end
        end
      end
      if (!rstn) chk_en = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 3; i++) begin
          logic [31:0] dcv;
          logic [CW+DW-1:0] head;
          dcv  = (i == 0) ? 32'(dc0) : (i == 1) ? 32'(dc1) : 32'(dc2);
          head = (mc[i] > 0) ? mq[i][0] : '0;
          chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(mc[i] > 0));
          chk($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(head[DW-1:0]));
          chk($sformatf("out_ctrl[%0d]", i), 32'(oc[i]), 32'(head[CW+DW-1:DW]));
          chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(m_rdy(i)));
          chk($sformatf("drop_cnt[%0d]", i), dcv, 32'(md[i]));
        end
      end
    end
  end

  task automatic drive(input logic rn, input logic fl, input logic iv,
                       input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
    rstn = rn; flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_in_ready", 32'(ir[0]), 32'd0);
    chk("rst_drop_cnt", 32'(dc0), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("post_rst_in_ready", 32'(ir[0]), 32'd1);

    // Streaming 1,2,3 with out_ready=1
    drive(1'b1, 1'b0, 1'b1, 16'd1, 4'h3, 1'b1);
    chk("stream1_data", 32'(od[0]), 32'd1);
    chk("stream1_ctrl", 32'(oc[0]), 32'd3);
    drive(1'b1, 1'b0, 1'b1, 16'd2, 4'h4, 1'b1);
    chk("stream2_data", 32'(od[0]), 32'd2);
    chk("stream2_single", 32'(od[1]), 32'd2);
    drive(1'b1, 1'b0, 1'b1, 16'd3, 4'h5, 1'b1);
    chk("stream3_data", 32'(od[0]), 32'd3);
    chk("stream3_ready", 32'(ir[0]), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("drain_valid", 32'(ov[0]), 32'd0);
    chk("drain_ctrl", 32'(oc[0]), 32'd0);

    // Backpressure: 0xA, 0xB into a stalled stage
    drive(1'b1, 1'b0, 1'b1, 16'hA, 4'h6, 1'b0);
    chk("single_ready_stall", 32'(ir[1]), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 16'hB, 4'h7, 1'b0);
    chk("full_ready", 32'(ir[0]), 32'd0);
    chk("full_head", 32'(od[0]), 32'hA);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("full_head_stable", 32'(od[0]), 32'hA);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("bp_second", 32'(od[0]), 32'hB);
    chk("bp_ready_back", 32'(ir[0]), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("bp_empty", 32'(ov[0]), 32'd0);

    // Flush in FULL with a competing beat 0xC
    drive(1'b1, 1'b0, 1'b1, 16'h11, 4'h1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 16'h12, 4'h2, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 16'hC, 4'h9, 1'b0);
    chk("flush_valid", 32'(ov[0]), 32'd0);
    chk("flush_ctrl", 32'(oc[0]), 32'd0);
    chk("flush_drop", 32'(dc0), 32'd2);
    chk("flush_drop_single", 32'(dc1), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("flush_beat_lost", 32'(ov[0]), 32'd0);

    // Flush in ONE with a simultaneous release
    drive(1'b1, 1'b0, 1'b1, 16'h5, 4'h5, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("flush_rel_drop", 32'(dc0), 32'd2);

    // Repeated flush in FULL saturates the 2-bit counter
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b1, 16'h20, 4'h1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 16'h21, 4'h2, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    end
    chk("sat_drop", 32'(dc2), 32'd3);
    chk("wide_drop", 32'(dc0), 32'd6);

    // Reset while FULL
    drive(1'b1, 1'b0, 1'b1, 16'h30, 4'h3, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 16'h31, 4'h4, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("rst_full_valid", 32'(ov[0]), 32'd0);
    chk("rst_full_drop", 32'(dc0), 32'd0);
    chk("rst_full_ready", 32'(ir[0]), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("rst_release_ready", 32'(ir[0]), 32'd1);

    // Mixed traffic, model-checked every cycle
    for (int k = 0; k < 80; k++) begin
      drive(1'b1, 1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
            16'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
